// File: rtl/i2s_pkg.sv
// Shared constants and small helpers for the I2S transmit stage.
package i2s_pkg;

    // Default configuration of the transmit stage.
    localparam int SAMPLE_W_DEF   = 16;
    localparam int CLK_DIV_DEF    = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // Word-select level that marks the left channel (Philips I2S).
    localparam logic LRCLK_LEFT = 1'b0;

    // Number of BCLK periods in one stereo frame (two slots of sample_w bits).
    function automatic int frame_bits(input int sample_w);
        return 2 * sample_w;
    endfunction

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Word-select level for a slot: left slot gives LRCLK_LEFT, right slot its inverse.
    function automatic logic lrclk_for_slot(input logic right_slot);
        return LRCLK_LEFT ^ right_slot;
    endfunction

    localparam int FRAME_BITS = frame_bits(SAMPLE_W_DEF);
    localparam int LEVEL_W    = level_w(FIFO_DEPTH_DEF);

endpackage : i2s_pkg

// File: rtl/i2s_sync_fifo.sv
// Synchronous sample-pair FIFO with first-word-fall-through read data.
// Pointers and occupancy are registered; full/empty decode the occupancy.
module i2s_sync_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Status flags come only from the registered occupancy; requests are gated by them.
    always_comb begin
        full_s  = (level_q == LVL_W'(DEPTH));
        empty_s = (level_q == {LVL_W{1'b0}});
        push_s  = wr_en_i & ~full_s;
        pop_s   = rd_en_i & ~empty_s;
    end

    // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; cleared on reset so no stale sample can ever reach the pads.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign level_o   = level_q;

endmodule : i2s_sync_fifo

// File: rtl/i2s_tx_stage.sv
// I2S transmit stage: buffers stereo sample pairs and serialises them as
// Philips-I2S frames. An empty FIFO at frame start sends silence and pulses
// underrun_o instead of stalling the bus.
module i2s_tx_stage
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        en_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [SAMPLE_W-1:0]         s_left_i,
    input  logic [SAMPLE_W-1:0]         s_right_i,
    output logic                        i2s_bclk_o,
    output logic                        i2s_lrclk_o,
    output logic                        i2s_sdata_o,
    output logic                        underrun_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int FRAME_W = frame_bits(SAMPLE_W);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LVL_W   = level_w(FIFO_DEPTH);

    // Serialiser state
    logic [DIV_W-1:0]   div_cnt_q;
    logic [DIV_W-1:0]   div_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_d;
    logic               bclk_q;
    logic               bclk_d;
    logic               lrclk_q;
    logic               lrclk_d;
    logic               sdata_q;
    logic               sdata_d;
    logic               underrun_q;
    logic               underrun_d;

    // Internal strobes
    logic               tick_s;
    logic               fall_s;
    logic [CNT_W-1:0]   bit_next_s;
    logic               push_s;
    logic               pop_s;

    // FIFO interface
    logic [FRAME_W-1:0] fifo_data_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LVL_W-1:0]   fifo_level_s;

    i2s_sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (push_s),
        .wr_data_i ({s_left_i, s_right_i}),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .level_o   (fifo_level_s)
    );

    // Upstream handshake: ready depends only on the registered occupancy, never on a pop.
    always_comb begin
        push_s = s_valid_i & ~fifo_full_s;
    end

    // Divider, bit counter and shifter next-state. Disabling returns the serialiser
    // to its idle state in one edge so a later enable always starts a fresh frame.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        pop_s      = 1'b0;
        tick_s     = 1'b0;
        fall_s     = 1'b0;
        bit_next_s = bit_cnt_q;
        if (en_i) begin
            tick_s = (div_cnt_q == DIV_W'(CLK_DIV - 1));
            fall_s = tick_s & bclk_q;
            if (tick_s) begin
                div_cnt_d = {DIV_W{1'b0}};
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            if (fall_s) begin
                // Data changes on the falling BCLK; the MSB leaving here is one
                // BCLK behind the word-select change, giving the I2S delay.
                if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                    bit_next_s = {CNT_W{1'b0}};
                end else begin
                    bit_next_s = bit_cnt_q + CNT_W'(1);
                end
                bit_cnt_d = bit_next_s;
                lrclk_d   = lrclk_for_slot(bit_next_s >= CNT_W'(SAMPLE_W));
                sdata_d   = sr_q[FRAME_W-1];
                if (bit_next_s == {CNT_W{1'b0}}) begin
                    // Frame start: load the next pair, or silence if none is queued.
                    pop_s = 1'b1;
                    if (fifo_empty_s) begin
                        sr_d       = {FRAME_W{1'b0}};
                        underrun_d = 1'b1;
                    end else begin
                        sr_d       = fifo_data_s;
                        underrun_d = 1'b0;
                    end
                end else begin
                    sr_d = {sr_q[FRAME_W-2:0], 1'b0};
                end
            end else begin
                bit_next_s = bit_cnt_q;
            end
        end else begin
            div_cnt_d = {DIV_W{1'b0}};
            bit_cnt_d = CNT_W'(FRAME_W - 1);
            sr_d      = {FRAME_W{1'b0}};
            bclk_d    = 1'b0;
            lrclk_d   = LRCLK_LEFT;
            sdata_d   = 1'b0;
        end
    end

    // Serialiser state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            div_cnt_q  <= {DIV_W{1'b0}};
            bit_cnt_q  <= CNT_W'(FRAME_W - 1);
            sr_q       <= {FRAME_W{1'b0}};
            bclk_q     <= 1'b0;
            lrclk_q    <= LRCLK_LEFT;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_ready_o    = ~fifo_full_s;
    assign i2s_bclk_o   = bclk_q;
    assign i2s_lrclk_o  = lrclk_q;
    assign i2s_sdata_o  = sdata_q;
    assign underrun_o   = underrun_q;
    assign fifo_level_o = fifo_level_s;

endmodule : i2s_tx_stage

// File: tb/tb_i2s_tx_stage.sv
// Directed bench for i2s_tx_stage (SAMPLE_W=16, CLK_DIV=2, FIFO_DEPTH=4).
module tb_i2s_tx_stage;

    localparam int SW = 16;
    localparam int CD = 2;
    localparam int FD = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          en_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [SW-1:0] s_left_i;
    logic [SW-1:0] s_right_i;
    logic          i2s_bclk_o;
    logic          i2s_lrclk_o;
    logic          i2s_sdata_o;
    logic          underrun_o;
    logic [2:0]    fifo_level_o;

    int checks   = 0;
    int failures = 0;

    i2s_tx_stage #(.SAMPLE_W(SW), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .en_i         (en_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_left_i     (s_left_i),
        .s_right_i    (s_right_i),
        .i2s_bclk_o   (i2s_bclk_o),
        .i2s_lrclk_o  (i2s_lrclk_o),
        .i2s_sdata_o  (i2s_sdata_o),
        .underrun_o   (underrun_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: records sdata/lrclk at every BCLK rising edge and every underrun pulse.
    int unsigned cyc = 0;
    bit          sd_q[$];
    bit          lr_q[$];
    int unsigned rise_t[$];
    int unsigned ur_t[$];
    logic        bclk_prev = 1'b0;

    always @(posedge clk_i) begin
        #1;
        cyc = cyc + 1;
        if (bclk_prev === 1'b0 && i2s_bclk_o === 1'b1) begin
            sd_q.push_back(i2s_sdata_o);
            lr_q.push_back(i2s_lrclk_o);
            rise_t.push_back(cyc);
        end
        if (underrun_o === 1'b1) ur_t.push_back(cyc);
        bclk_prev = i2s_bclk_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        sd_q.delete();
        lr_q.delete();
        rise_t.delete();
        ur_t.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rstn_i = 1'b0; en_i = 1'b0; s_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int k = 0;
        @(negedge clk_i);
        s_left_i = l; s_right_i = r; s_valid_i = 1'b1;
        while (s_ready_o !== 1'b1 && k < 400) begin
            @(negedge clk_i);
            k++;
        end
        if (s_ready_o !== 1'b1) begin
            checks++; failures++;
            $display("FAIL push_timeout: ready=%b after %0d cycles, required 1", s_ready_o, k);
        end
        @(negedge clk_i);
        s_valid_i = 1'b0;
    endtask

    task automatic wait_samples(input int n, input int budget);
        int k = 0;
        while (sd_q.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        if (sd_q.size() < n) begin
            checks++; failures++;
            $display("FAIL sample_timeout: got %0d bclk samples, required %0d", sd_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_i = 1'($urandom); s_valid_i = 1'($urandom);
            s_left_i = SW'($urandom); s_right_i = SW'($urandom);
            @(negedge clk_i);
        end
        checks++; if (i2s_bclk_o !== 1'b0) begin failures++; $display("FAIL reset_bclk: got %b required 0", i2s_bclk_o); end
        checks++; if (i2s_lrclk_o !== 1'b0) begin failures++; $display("FAIL reset_lrclk: got %b required 0", i2s_lrclk_o); end
        checks++; if (i2s_sdata_o !== 1'b0) begin failures++; $display("FAIL reset_sdata: got %b required 0", i2s_sdata_o); end
        checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b required 0", underrun_o); end
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", s_ready_o); end
        checks++; if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d required 0", fifo_level_o); end
        en_i = 1'b0; s_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++; if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL reset_release_level: got %0d required 0", fifo_level_o); end
    endtask

    task automatic test_single_frame();
        logic [SW-1:0] lv;
        logic [SW-1:0] rv;
        lv = 16'hA5C3; rv = 16'h0F01;
        apply_reset();
        push_pair(lv, rv);
        checks++; if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL single_level: got %0d required 1", fifo_level_o); end
        clear_mon();
        en_i = 1'b1;
        for (int n = 1; n <= 4 * CD; n++) begin
            @(posedge clk_i); #2;
            if (n == CD - 1) begin
                checks++; if (i2s_bclk_o !== 1'b0) begin failures++; $display("FAIL single_bclk_early: got %b required 0", i2s_bclk_o); end
            end
            if (n == CD) begin
                checks++; if (i2s_bclk_o !== 1'b1) begin failures++; $display("FAIL single_bclk_first_rise: got %b required 1", i2s_bclk_o); end
            end
            if (n == 4 * CD - 1) begin
                checks++; if (i2s_sdata_o !== 1'b0) begin failures++; $display("FAIL single_sdata_pre: got %b required 0", i2s_sdata_o); end
            end
            if (n == 4 * CD) begin
                checks++; if (i2s_sdata_o !== 1'b1) begin failures++; $display("FAIL single_l_msb_latency: got %b required 1", i2s_sdata_o); end
            end
        end
        wait_samples(33, 400);
        checks++; if (ur_t.size() != 0) begin failures++; $display("FAIL single_no_underrun: got %0d pulses required 0", ur_t.size()); end
        wait_samples(34, 100);
        checks++; if (sd_q[1] !== 1'b0) begin failures++; $display("FAIL single_bit0: got %b required 0", sd_q[1]); end
        for (int i = 0; i < SW; i++) begin
            checks++; if (sd_q[2 + i] !== lv[SW - 1 - i]) begin failures++; $display("FAIL single_left bit %0d: got %b required %b", i, sd_q[2 + i], lv[SW - 1 - i]); end
            checks++; if (sd_q[18 + i] !== rv[SW - 1 - i]) begin failures++; $display("FAIL single_right bit %0d: got %b required %b", i, sd_q[18 + i], rv[SW - 1 - i]); end
        end
        for (int i = 1; i <= 33; i++) begin
            checks++; if (lr_q[i] !== bit'(i >= 17 && i <= 32)) begin failures++; $display("FAIL single_lrclk rise %0d: got %b required %b", i, lr_q[i], (i >= 17 && i <= 32)); end
        end
        checks++; if (rise_t[2] - rise_t[1] != 4) begin failures++; $display("FAIL single_bclk_period: got %0d clk required 4", rise_t[2] - rise_t[1]); end
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 4; i++) push_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        checks++; if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL bp_full_level: got %0d required 4", fifo_level_o); end
        checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b required 0", s_ready_o); end
        @(negedge clk_i);
        s_left_i = 16'h1004; s_right_i = 16'h2004; s_valid_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++; if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL bp_held_level: got %0d required 4", fifo_level_o); end
        en_i = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk_i);
            if (n < 4) begin
                checks++; if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL bp_level n=%0d: got %0d required 4", n, fifo_level_o); end
            end
            if (n == 4) begin
                checks++; if (fifo_level_o !== 3'd3) begin failures++; $display("FAIL bp_after_pop_level: got %0d required 3", fifo_level_o); end
                checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL bp_after_pop_ready: got %b required 1", s_ready_o); end
            end
            if (n == 5) begin
                checks++; if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL bp_refill_level: got %0d required 4", fifo_level_o); end
                s_valid_i = 1'b0;
            end
            if (n == 6) begin
                checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL bp_refill_ready: got %b required 0", s_ready_o); end
            end
        end
        apply_reset();
        checks++; if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL bp_reset_flush: got %0d required 0", fifo_level_o); end
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL bp_reset_ready: got %b required 1", s_ready_o); end
    endtask

    task automatic test_underrun();
        int unsigned e0;
        int          ones;
        int          k;
        logic [SW-1:0] lv;
        logic [SW-1:0] rv;
        lv = 16'h8001; rv = 16'h4002;
        apply_reset();
        clear_mon();
        e0 = cyc;
        en_i = 1'b1;
        k = 0;
        while (ur_t.size() < 3 && k < 600) begin
            @(negedge clk_i);
            k++;
        end
        checks++; if (ur_t.size() < 3) begin failures++; $display("FAIL ur_timeout: got %0d pulses required 3", ur_t.size()); end
        checks++; if (ur_t[0] != e0 + 4) begin failures++; $display("FAIL ur_first: got cycle %0d required %0d", ur_t[0], e0 + 4); end
        checks++; if (ur_t[1] - ur_t[0] != 128) begin failures++; $display("FAIL ur_period1: got %0d required 128", ur_t[1] - ur_t[0]); end
        checks++; if (ur_t[2] - ur_t[1] != 128) begin failures++; $display("FAIL ur_period2: got %0d required 128", ur_t[2] - ur_t[1]); end
        ones = 0;
        foreach (sd_q[i]) ones += int'(sd_q[i]);
        checks++; if (ones != 0) begin failures++; $display("FAIL ur_silence: got %0d ones required 0", ones); end
        clear_mon();
        push_pair(lv, rv);
        wait_samples(64, 400);
        checks++; if (ur_t.size() != 0) begin failures++; $display("FAIL ur_refilled_frame: got %0d pulses required 0", ur_t.size()); end
        wait_samples(65, 50);
        ones = 0;
        for (int i = 0; i <= 32; i++) ones += int'(sd_q[i]);
        checks++; if (ones != 0) begin failures++; $display("FAIL ur_silent_frame: got %0d ones required 0", ones); end
        for (int i = 0; i < SW; i++) begin
            checks++; if (sd_q[33 + i] !== lv[SW - 1 - i]) begin failures++; $display("FAIL ur_left bit %0d: got %b required %b", i, sd_q[33 + i], lv[SW - 1 - i]); end
            checks++; if (sd_q[49 + i] !== rv[SW - 1 - i]) begin failures++; $display("FAIL ur_right bit %0d: got %b required %b", i, sd_q[49 + i], rv[SW - 1 - i]); end
        end
        checks++; if (ur_t.size() != 1) begin failures++; $display("FAIL ur_next_empty: got %0d pulses required 1", ur_t.size()); end
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    task automatic test_mid_disable();
        apply_reset();
        push_pair(16'hFFFF, 16'h0000);
        push_pair(16'h9ABC, 16'h1357);
        clear_mon();
        en_i = 1'b1;
        wait_samples(12, 200);
        checks++; if (i2s_bclk_o !== 1'b1) begin failures++; $display("FAIL md_pre_bclk: got %b required 1", i2s_bclk_o); end
        checks++; if (i2s_sdata_o !== 1'b1) begin failures++; $display("FAIL md_pre_sdata: got %b required 1", i2s_sdata_o); end
        checks++; if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL md_pre_level: got %0d required 1", fifo_level_o); end
        en_i = 1'b0;
        @(posedge clk_i); #2;
        checks++; if (i2s_bclk_o !== 1'b0) begin failures++; $display("FAIL md_bclk: got %b required 0", i2s_bclk_o); end
        checks++; if (i2s_lrclk_o !== 1'b0) begin failures++; $display("FAIL md_lrclk: got %b required 0", i2s_lrclk_o); end
        checks++; if (i2s_sdata_o !== 1'b0) begin failures++; $display("FAIL md_sdata: got %b required 0", i2s_sdata_o); end
        checks++; if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL md_level_kept: got %0d required 1", fifo_level_o); end
        repeat (3) @(negedge clk_i);
        en_i = 1'b1;
        for (int n = 1; n <= 4 * CD; n++) begin
            @(posedge clk_i); #2;
            if (n == CD - 1) begin
                checks++; if (i2s_bclk_o !== 1'b0) begin failures++; $display("FAIL md_re_bclk_early: got %b required 0", i2s_bclk_o); end
            end
            if (n == CD) begin
                checks++; if (i2s_bclk_o !== 1'b1) begin failures++; $display("FAIL md_re_bclk_rise: got %b required 1", i2s_bclk_o); end
            end
            if (n == 2 * CD) begin
                checks++; if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL md_re_pop: got %0d required 0", fifo_level_o); end
            end
            if (n == 4 * CD - 1) begin
                checks++; if (i2s_sdata_o !== 1'b0) begin failures++; $display("FAIL md_re_sdata_pre: got %b required 0", i2s_sdata_o); end
            end
            if (n == 4 * CD) begin
                checks++; if (i2s_sdata_o !== 1'b1) begin failures++; $display("FAIL md_re_l_msb: got %b required 1", i2s_sdata_o); end
                checks++; if (i2s_lrclk_o !== 1'b0) begin failures++; $display("FAIL md_re_lrclk: got %b required 0", i2s_lrclk_o); end
            end
        end
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] lv [3];
        logic [SW-1:0] rv [3];
        lv[0] = 16'h8421; rv[0] = 16'h1248;
        lv[1] = 16'h7E7E; rv[1] = 16'h0180;
        lv[2] = 16'hF00F; rv[2] = 16'h5A5A;
        apply_reset();
        push_pair(lv[0], rv[0]);
        push_pair(lv[1], rv[1]);
        checks++; if (fifo_level_o !== 3'd2) begin failures++; $display("FAIL b2b_level_before: got %0d required 2", fifo_level_o); end
        clear_mon();
        en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        s_left_i = lv[2]; s_right_i = rv[2]; s_valid_i = 1'b1;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        checks++; if (fifo_level_o !== 3'd2) begin failures++; $display("FAIL b2b_level_pushpop: got %0d required 2", fifo_level_o); end
        checks++; if (ur_t.size() != 0) begin failures++; $display("FAIL b2b_no_underrun: got %0d pulses required 0", ur_t.size()); end
        wait_samples(98, 800);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < SW; i++) begin
                checks++; if (sd_q[2 + 32 * f + i] !== lv[f][SW - 1 - i]) begin failures++; $display("FAIL b2b_left frame %0d bit %0d: got %b required %b", f, i, sd_q[2 + 32 * f + i], lv[f][SW - 1 - i]); end
                checks++; if (sd_q[18 + 32 * f + i] !== rv[f][SW - 1 - i]) begin failures++; $display("FAIL b2b_right frame %0d bit %0d: got %b required %b", f, i, sd_q[18 + 32 * f + i], rv[f][SW - 1 - i]); end
            end
        end
        checks++; if (ur_t.size() != 1) begin failures++; $display("FAIL b2b_drained: got %0d pulses required 1", ur_t.size()); end
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    initial begin
        rstn_i = 1'b0; en_i = 1'b0; s_valid_i = 1'b0;
        s_left_i = 16'h0000; s_right_i = 16'h0000;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_underrun();
        test_mid_disable();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_i2s_tx_stage
